// File: rtl/seven_segment_mux.sv
// Time-multiplexed multi-digit seven-segment driver with frame-synchronous (tear-free) updates.
// Optional decimal points are added when SSEG_DP_EN is defined.
module seven_segment_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1,
    parameter int HEX_MODE     = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] numin,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
`ifdef SSEG_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp_out,
`endif
    output logic [6:0]              segout,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pend_val, act_val;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
    logic                    pend_valid;
`ifdef SSEG_DP_EN
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
`endif

    logic                  slot_end, wrap;
    logic [3:0]            cur_val;
    logic                  cur_blank;
    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] anode_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && v > 4'd9) g = 7'h7F;
        return g;
    endfunction

    assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
    assign wrap     = slot_end && (idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        cur_val   = act_val[{idx, 2'b00} +: 4];
        cur_blank = act_blank[idx];
        seg_nxt   = cur_blank ? 7'h7F : decode(cur_val);
        anode_nxt = '1;
        // The first BLANK_CYCLES of each slot keep every anode off to suppress ghosting.
        if (cnt >= CW'(BLANK_CYCLES) && !cur_blank) anode_nxt[idx] = 1'b0;
    end

    // load is a one-cycle strobe with no back-pressure: it is always accepted and the
    // newest load wins; pending data becomes visible only at the next wrap edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            act_val    <= '0;
            pend_blank <= '1;
            act_blank  <= '1;
            segout     <= 7'h7F;
            anode      <= '1;
            frame_tick <= 1'b0;
`ifdef SSEG_DP_EN
            pend_dp    <= '0;
            act_dp     <= '0;
            dp_out     <= 1'b1;
`endif
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            segout     <= seg_nxt;
            anode      <= anode_nxt;
            frame_tick <= wrap;
`ifdef SSEG_DP_EN
            dp_out     <= cur_blank ? 1'b1 : ~act_dp[idx];
`endif
            if (wrap && pend_valid) begin
                act_val    <= pend_val;
                act_blank  <= pend_blank;
`ifdef SSEG_DP_EN
                act_dp     <= pend_dp;
`endif
                pend_valid <= 1'b0;
            end
            // Placed after the transfer so a load on the wrap edge keeps pend_valid set.
            if (load) begin
                pend_val   <= numin;
                pend_blank <= blank_in;
`ifdef SSEG_DP_EN
                pend_dp    <= dp_in;
`endif
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: a hex-mode and a BCD-mode instance share stimulus and are
// checked every cycle against a time-based reference model, plus table and directed checks.
module tb_seven_segment_mux;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FR = ND * RD;

    logic        Clk = 1'b0;
    logic        Rst, load;
    logic [15:0] numin;
    logic [3:0]  blank_in;
    logic [6:0]  segout, seg_bcd;
    logic [3:0]  anode, anode_bcd;
    logic        frame_tick, tick_bcd;
    logic        dp_obs;

    always #5 Clk = ~Clk;

`ifdef SSEG_DP_EN
    logic [3:0] dp_drv = 4'b0001;
    logic       dp_bcd;
    seven_segment_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(1)) u_dut (
        .Clk(Clk), .Rst(Rst), .numin(numin), .blank_in(blank_in), .load(load),
        .dp_in(dp_drv), .dp_out(dp_obs),
        .segout(segout), .anode(anode), .frame_tick(frame_tick));
    seven_segment_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(0)) u_bcd (
        .Clk(Clk), .Rst(Rst), .numin(numin), .blank_in(blank_in), .load(load),
        .dp_in(dp_drv), .dp_out(dp_bcd),
        .segout(seg_bcd), .anode(anode_bcd), .frame_tick(tick_bcd));
`else
    assign dp_obs = 1'b1;
    seven_segment_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(1)) u_dut (
        .Clk(Clk), .Rst(Rst), .numin(numin), .blank_in(blank_in), .load(load),
        .segout(segout), .anode(anode), .frame_tick(frame_tick));
    seven_segment_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(0)) u_bcd (
        .Clk(Clk), .Rst(Rst), .numin(numin), .blank_in(blank_in), .load(load),
        .segout(seg_bcd), .anode(anode_bcd), .frame_tick(tick_bcd));
`endif

    logic [6:0] glyphs [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reference model: time since reset plus the two data buffers.
    int         c;
    logic [3:0] m_av [ND];
    logic [3:0] m_pv [ND];
    logic       m_ab [ND];
    logic       m_pb [ND];
    logic       m_pvalid;
`ifdef SSEG_DP_EN
    logic       m_adp [ND];
    logic       m_pdp [ND];
`endif

    logic [19:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] num, input logic [3:0] blk);
        int d, p;
        logic b, dpe;
        logic [3:0] an;
        logic [6:0] sh, sb;
        logic [19:0] exp_v;
        Rst = r; load = ld; numin = num; blank_in = blk;
        d = (c / RD) % ND;
        p = c % RD;
        b = m_ab[d];
        an = 4'hF;
        if (p >= BC && !b) an[d] = 1'b0;
        sh = b ? 7'h7F : glyphs[m_av[d]];
        sb = (b || m_av[d] > 4'd9) ? 7'h7F : glyphs[m_av[d]];
`ifdef SSEG_DP_EN
        dpe = b ? 1'b1 : ~m_adp[d];
`else
        dpe = 1'b1;
`endif
        exp_v = r ? {7'h7F, 7'h7F, 4'hF, 1'b0, 1'b1}
                  : {sh, sb, an, (c % FR == FR - 1), dpe};
        exp_q.push_back(exp_v);
        @(posedge Clk);
        #1;
        chk("scan", {segout, seg_bcd, anode, frame_tick, dp_obs}, exp_q.pop_front());
        if (r) begin
            c = 0;
            m_pvalid = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_av[i] = 4'h0; m_pv[i] = 4'h0; m_ab[i] = 1'b1; m_pb[i] = 1'b1;
`ifdef SSEG_DP_EN
                m_adp[i] = 1'b0; m_pdp[i] = 1'b0;
`endif
            end
        end else begin
            if (c % FR == FR - 1 && m_pvalid) begin
                m_av = m_pv; m_ab = m_pb;
`ifdef SSEG_DP_EN
                m_adp = m_pdp;
`endif
                m_pvalid = 1'b0;
            end
            if (ld) begin
                for (int i = 0; i < ND; i++) begin
                    m_pv[i] = num[4*i +: 4];
                    m_pb[i] = blk[i];
`ifdef SSEG_DP_EN
                    m_pdp[i] = dp_drv[i];
`endif
                end
                m_pvalid = 1'b1;
            end
            c++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, numin, blank_in);
    endtask

    typedef struct {
        logic [15:0] num;
        logic [3:0]  blk;
        logic [6:0]  seg_hex;
        logic [6:0]  seg_bcd;
        logic [3:0]  an;
    } vec_t;

    initial begin
        vec_t vecs [7];
        logic low_seen;
        vecs[0] = '{16'h1234, 4'b0000, 7'b1001100, 7'b1001100, 4'b1110};
        vecs[1] = '{16'h000A, 4'b0000, 7'b0001000, 7'h7F,      4'b1110};
        vecs[2] = '{16'h000F, 4'b0000, 7'b0111000, 7'h7F,      4'b1110};
        vecs[3] = '{16'h0008, 4'b0000, 7'b0000000, 7'b0000000, 4'b1110};
        vecs[4] = '{16'h0000, 4'b0001, 7'h7F,      7'h7F,      4'b1111};
        vecs[5] = '{16'h000B, 4'b0000, 7'b1100000, 7'h7F,      4'b1110};
        vecs[6] = '{16'h0007, 4'b0000, 7'b0001111, 7'b0001111, 4'b1110};
        c = 0;
        m_pvalid = 1'b0;

        // Reset held three cycles, then a full frame with nothing loaded.
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
        chk("reset_seg", segout, 7'h7F);
        idle(FR);
        chk("no_load_anode", anode, 4'hF);

        // Each vector: load at frame start, then inspect digit 0 in the following frame.
        for (int v = 0; v < 7; v++) begin
            step(1'b0, 1'b1, vecs[v].num, vecs[v].blk);
            idle(FR - 1);
            idle(1);
            chk($sformatf("v%0d_guard", v), anode, 4'hF);
            idle(1);
            chk($sformatf("v%0d_seg", v), segout, vecs[v].seg_hex);
            chk($sformatf("v%0d_bcd", v), seg_bcd, vecs[v].seg_bcd);
            chk($sformatf("v%0d_anode", v), anode, vecs[v].an);
            idle(FR - 2);
        end

        // Mid-frame load is deferred; a load on the wrap edge waits one more frame.
        idle(5);
        step(1'b0, 1'b1, 16'h5678, 4'h0);
        idle(9);
        step(1'b0, 1'b1, 16'h9999, 4'h0);
        idle(2);
        chk("upd_5678", segout, 7'b0000000);
        idle(FR - 2);
        idle(2);
        chk("upd_9999", segout, 7'b0000100);
        idle(FR - 2);

        // Digit 2 blanked for three frames.
        step(1'b0, 1'b1, 16'h1234, 4'b0100);
        idle(FR - 1);
        low_seen = 1'b0;
        for (int i = 0; i < 3 * FR; i++) begin
            idle(1);
            if (!anode[2]) low_seen = 1'b1;
        end
        chk("blank_digit2", low_seen, 1'b0);

        // Reset in the middle of digit 2's slot, then restart.
        idle(9);
        step(1'b1, 1'b0, numin, blank_in);
        chk("midrst_seg", segout, 7'h7F);
        chk("midrst_anode", anode, 4'hF);
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        idle(FR - 1);
        idle(2);
        chk("restart_d0", anode, 4'b1110);
        idle(FR - 2);

        // Random loads and occasional resets against the model.
        for (int i = 0; i < 600; i++) begin
`ifdef SSEG_DP_EN
            dp_drv = 4'($urandom_range(0, 15));
`endif
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
